// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (HSync/VSync/DE), prefetching pixel
// reader and output formatter (pass-through, line-alternating checkerboard, colour bars).
// Latency: sync/DE/pixel lag h_cnt/v_cnt by 1 cycle; Mem_Read leads Out_pVDE by PREFETCH.
// Backpressure: none. Memory must answer PREFETCH-1 cycles after each strobe; a pixel
// without Mem_Valid is blanked and counted in Deb_Underrun (saturating).
// Ports: clk/rst (sync, active high), En run enable, Mode format select, FraimSync
// checkerboard seed; Mem_Read/Mem_Addr/Mem_Data/Mem_Valid frame-store read port;
// Out_p* pixel/sync to the TMDS encoder; Deb_* debug counters.
// Assumes PREFETCH <= H_SYNC+H_BP and H_ACTIVE >= 8.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   DATA_W   = 24,
  parameter int   ADDR_W   = 20,
  parameter int   PREFETCH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic [1:0]        Mode,
  input  logic              FraimSync,
  output logic              Mem_Read,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data,
  input  logic              Mem_Valid,
  output logic [DATA_W-1:0] Out_pData,
  output logic              Out_pHSync,
  output logic              Out_pVSync,
  output logic              Out_pVDE,
  output logic [15:0]       Deb_Hcnt,
  output logic [15:0]       Deb_Vcnt,
  output logic [31:0]       Deb_Frame_cnt,
  output logic [15:0]       Deb_Underrun
);

  localparam int CW = DATA_W / 3;
  localparam logic [15:0] H_LAST = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] V_LAST = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [15:0] HS_END = 16'(H_SYNC);
  localparam logic [15:0] VS_END = 16'(V_SYNC);
  localparam logic [15:0] HA_BEG = 16'(H_SYNC + H_BP);
  localparam logic [15:0] HA_END = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] VA_BEG = 16'(V_SYNC + V_BP);
  localparam logic [15:0] VA_END = 16'(V_SYNC + V_BP + V_ACTIVE);
  // Read window is the active window shifted PREFETCH cycles earlier on the same line.
  localparam logic [15:0] HR_BEG = 16'(H_SYNC + H_BP - PREFETCH);
  localparam logic [15:0] HR_END = 16'(H_SYNC + H_BP + H_ACTIVE - PREFETCH);
  localparam logic [16:0] HA_W   = 17'(H_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t state_q, state_d;
  logic   run_en;

  logic [15:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              line_par_q, line_par_d;
  logic [16:0]       rem_q, rem_d;
  logic [2:0]        bar_q, bar_d;
  logic              rd_q, rd_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       fc_q, fc_d;
  logic [15:0]       und_q, und_d;

  logic h_last, v_last, frame_wrap, frame_start;
  logic h_act, v_act, pix, px_lsb;
  logic [16:0]       rem_sum;
  logic [DATA_W-1:0] bar_pix;

  assign h_last      = (h_cnt_q == H_LAST);
  assign v_last      = (v_cnt_q == V_LAST);
  assign frame_wrap  = h_last && v_last;
  assign frame_start = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
  assign h_act       = (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END);
  assign v_act       = (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
  assign pix         = run_en && h_act && v_act;
  // px = h_cnt - HA_BEG, so its LSB is just an XOR.
  assign px_lsb      = h_cnt_q[0] ^ HA_BEG[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (En) state_d = S_RUN;
      S_RUN:   if (!En) state_d = S_STOP;
      S_STOP:  if (En) state_d = S_RUN;
               else if (frame_wrap) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    run_en = 1'b0;
    case (state_q)
      S_RUN, S_STOP: run_en = 1'b1;
      default:       run_en = 1'b0;
    endcase
  end

  always_comb begin
    // Raster counters: held at 0 while idle.
    h_cnt_d = 16'd0;
    v_cnt_d = 16'd0;
    if (run_en) begin
      h_cnt_d = h_last ? 16'd0 : h_cnt_q + 16'd1;
      v_cnt_d = v_cnt_q;
      if (h_last) v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;
    end

    // Per-frame configuration, captured while the raster sits at (0,0).
    mode_d     = frame_start ? Mode : mode_q;
    line_par_d = line_par_q;
    if (frame_start)                           line_par_d = FraimSync;
    else if (pix && h_cnt_q == HA_END - 16'd1) line_par_d = ~line_par_q;

    // Bar index b = px*8/H_ACTIVE tracked incrementally: rem = px*8 mod H_ACTIVE.
    rem_sum = rem_q + 17'd8;
    rem_d   = 17'd0;
    bar_d   = 3'd0;
    if (pix) begin
      if (rem_sum >= HA_W) begin
        rem_d = rem_sum - HA_W;
        bar_d = bar_q + 3'd1;
      end else begin
        rem_d = rem_sum;
        bar_d = bar_q;
      end
    end
    bar_pix = {{CW{~bar_q[2]}}, {CW{~bar_q[1]}}, {CW{~bar_q[0]}}};

    data_d = '0;
    und_d  = und_q;
    if (pix) begin
      case (mode_q)
        2'd2:    data_d = bar_pix;
        2'd1:    data_d = (Mem_Valid && (px_lsb == line_par_q)) ? Mem_Data : '0;
        default: data_d = Mem_Valid ? Mem_Data : '0;
      endcase
      if (mode_q != 2'd2 && !Mem_Valid && und_q != 16'hFFFF) und_d = und_q + 16'd1;
    end

    de_d = pix;
    rd_d = run_en && v_act && (h_cnt_q >= HR_BEG) && (h_cnt_q < HR_END);
    hs_d = (run_en && h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
    vs_d = (run_en && v_cnt_q < VS_END) ? VS_POL : ~VS_POL;

    addr_d = addr_q;
    if (frame_start) addr_d = '0;
    else if (rd_q)   addr_d = addr_q + ADDR_W'(1);

    fc_d = (run_en && frame_wrap) ? fc_q + 32'd1 : fc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q    <= 16'd0;
      v_cnt_q    <= 16'd0;
      mode_q     <= 2'd0;
      line_par_q <= 1'b0;
      rem_q      <= 17'd0;
      bar_q      <= 3'd0;
      rd_q       <= 1'b0;
      de_q       <= 1'b0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      addr_q     <= '0;
      data_q     <= '0;
      fc_q       <= 32'd0;
      und_q      <= 16'd0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      mode_q     <= mode_d;
      line_par_q <= line_par_d;
      rem_q      <= rem_d;
      bar_q      <= bar_d;
      rd_q       <= rd_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fc_q       <= fc_d;
      und_q      <= und_d;
    end
  end

  assign Mem_Read      = rd_q;
  assign Mem_Addr      = addr_q;
  assign Out_pData     = data_q;
  assign Out_pHSync    = hs_q;
  assign Out_pVSync    = vs_q;
  assign Out_pVDE      = de_q;
  assign Deb_Hcnt      = h_cnt_q;
  assign Deb_Vcnt      = v_cnt_q;
  assign Deb_Frame_cnt = fc_q;
  assign Deb_Underrun  = und_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen on a small raster
// (12x4 active, 19x7 total). Memory model returns data = address, PREFETCH-1 cycles late.
module tb_video_timing_gen;

  localparam int HA = 12, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int PF = 3, DW = 24, AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          En = 1'b0;
  logic [1:0]    Mode = 2'd0;
  logic          FraimSync = 1'b1;
  logic          Mem_Read;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_Data;
  logic          Mem_Valid;
  logic [DW-1:0] Out_pData;
  logic          Out_pHSync, Out_pVSync, Out_pVDE;
  logic [15:0]   Deb_Hcnt, Deb_Vcnt, Deb_Underrun;
  logic [31:0]   Deb_Frame_cnt;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DW), .ADDR_W(AW), .PREFETCH(PF)
  ) dut (
    .clk(clk), .rst(rst), .En(En), .Mode(Mode), .FraimSync(FraimSync),
    .Mem_Read(Mem_Read), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data), .Mem_Valid(Mem_Valid),
    .Out_pData(Out_pData), .Out_pHSync(Out_pHSync), .Out_pVSync(Out_pVSync),
    .Out_pVDE(Out_pVDE), .Deb_Hcnt(Deb_Hcnt), .Deb_Vcnt(Deb_Vcnt),
    .Deb_Frame_cnt(Deb_Frame_cnt), .Deb_Underrun(Deb_Underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: two-stage pipe so data lands PF-1 cycles after the strobe.
  logic          p0_rd = 1'b0, p1_rd = 1'b0;
  logic [AW-1:0] p0_a = '0, p1_a = '0;
  logic          drop_en = 1'b0;
  always @(posedge clk) begin
    p0_rd <= Mem_Read;
    p0_a  <= Mem_Addr;
    p1_rd <= p0_rd;
    p1_a  <= p0_a;
  end
  assign Mem_Data  = {4'h0, p1_a};
  assign Mem_Valid = p1_rd && !(drop_en && p1_a >= 20'd10 && p1_a < 20'd15);

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  logic mon_on = 1'b0;
  logic sb_on  = 1'b1;

  // Hand-computed bars for px 0..11: b = floor(2*px/3) -> 0,0,1,2,2,3,4,4,5,6,6,7.
  logic [DW-1:0] bar_tbl [12] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF00FF,
                                  24'hFF00FF, 24'hFF0000, 24'h00FFFF, 24'h00FFFF,
                                  24'h00FF00, 24'h0000FF, 24'h0000FF, 24'h000000};

  task automatic push_frame(input int mode, input int fs, input int drop_lo, input int drop_hi);
    logic [DW-1:0] e;
    int a;
    int par;
    for (int l = 0; l < VA; l++) begin
      for (int p = 0; p < HA; p++) begin
        a   = l * HA + p;
        par = (fs + l) % 2;
        case (mode)
          2:       e = bar_tbl[p];
          1:       e = ((p % 2) == par) ? DW'(a) : '0;
          default: e = (a >= drop_lo && a < drop_hi) ? '0 : DW'(a);
        endcase
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: samples on the falling edge.
  initial begin
    logic [2:0]    mr_hist = 3'b000;
    logic          hs_prev = 1'b1, vs_prev = 1'b1;
    int            run_len = 0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("read_lead", 64'(Out_pVDE), 64'(mr_hist[2]));
        if (Out_pVDE) begin
          run_len++;
          if (sb_on) begin
            if (exp_q.size() == 0) chk("sb_pop", 64'(exp_q.size()), 64'd1);
            else begin
              e = exp_q.pop_front();
              chk("pixel", 64'(Out_pData), 64'(e));
            end
          end
        end else begin
          chk("blank_data", 64'(Out_pData), 64'd0);
          if (run_len != 0) chk("de_run", 64'(run_len), 64'(HA));
          run_len = 0;
        end
        if (Out_pVSync !== vs_prev)
          chk("vs_on_hs_lead", 64'({hs_prev, Out_pHSync}), 64'(2'b10));
      end else begin
        run_len = 0;
      end
      mr_hist = {mr_hist[1:0], Mem_Read};
      hs_prev = Out_pHSync;
      vs_prev = Out_pVSync;
    end
  end

  // Frame measurement over frame 1 (the 133 cycles while Deb_Frame_cnt == 1).
  initial begin
    int n = 0;
    int cyc = 0, hs_lo = 0, vs_lo = 0, de_n = 0;
    while (Deb_Frame_cnt != 32'd1 && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("meas_wait", 64'(n), 64'd0);
    while (Deb_Frame_cnt == 32'd1 && cyc < 400) begin
      if (!Out_pHSync) hs_lo++;
      if (!Out_pVSync) vs_lo++;
      if (Out_pVDE)    de_n++;
      cyc++;
      tick();
    end
    chk("frame_len",  64'(cyc),   64'(HT * VT));
    chk("hsync_low",  64'(hs_lo), 64'(HS * VT));
    chk("vsync_low",  64'(vs_lo), 64'(VS * HT));
    chk("de_cycles",  64'(de_n),  64'(HA * VA));
  end

  task automatic wait_fv(input int fc, input int v);
    int n = 0;
    while (!(Deb_Frame_cnt == 32'(fc) && (v < 0 || Deb_Vcnt == 16'(v))) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("wait_timeout", 64'(n), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_read"},  64'(Mem_Read),      64'd0);
    chk({tag, "_mem_addr"},  64'(Mem_Addr),      64'd0);
    chk({tag, "_pdata"},     64'(Out_pData),     64'd0);
    chk({tag, "_hsync"},     64'(Out_pHSync),    64'd1);
    chk({tag, "_vsync"},     64'(Out_pVSync),    64'd1);
    chk({tag, "_vde"},       64'(Out_pVDE),      64'd0);
    chk({tag, "_hcnt"},      64'(Deb_Hcnt),      64'd0);
    chk({tag, "_vcnt"},      64'(Deb_Vcnt),      64'd0);
    chk({tag, "_frame_cnt"}, 64'(Deb_Frame_cnt), 64'd0);
    chk({tag, "_underrun"},  64'(Deb_Underrun),  64'd0);
  endtask

  // Stimulus
  initial begin
    int n;
    int idle_bad;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    mon_on = 1'b1;

    // F0 mode 0; F1 mode 0 with addresses 10..14 starved.
    push_frame(0, 1, 0, 0);
    push_frame(0, 1, 10, 15);
    En = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!Out_pVDE && n < 200);
    chk("first_de_latency", 64'(n - 1), 64'((VS + VB) * HT + HS + HB + 1));

    wait_fv(1, -1);
    drop_en = 1'b1;
    wait_fv(1, 3);
    Mode = 2'd1; FraimSync = 1'b1;
    push_frame(1, 1, 0, 0);
    wait_fv(2, -1);
    drop_en = 1'b0;
    chk("underrun_5", 64'(Deb_Underrun), 64'd5);
    wait_fv(2, 3);
    FraimSync = 1'b0;
    push_frame(1, 0, 0, 0);
    wait_fv(3, 3);
    Mode = 2'd2;
    push_frame(2, 0, 0, 0);
    wait_fv(4, 3);
    Mode = 2'd0;               // mid-frame change: F4 must stay bars
    push_frame(0, 0, 0, 0);
    wait_fv(5, 3);
    push_frame(0, 0, 0, 0);
    wait_fv(6, 3);
    En = 1'b0;                 // F6 must still complete
    wait_fv(7, -1);

    idle_bad = 0;
    repeat (40) begin
      if (Deb_Hcnt != 16'd0 || Deb_Vcnt != 16'd0 || Out_pHSync !== 1'b1 ||
          Out_pVSync !== 1'b1 || Out_pVDE !== 1'b0 || Mem_Read !== 1'b0)
        idle_bad++;
      tick();
    end
    chk("idle_hold", 64'(idle_bad), 64'd0);
    chk("frame_cnt", 64'(Deb_Frame_cnt), 64'd7);
    chk("underrun_held", 64'(Deb_Underrun), 64'd5);
    chk("sb_left", 64'(exp_q.size()), 64'd0);

    // Restart, then reset in the middle of an active line.
    mon_on = 1'b0;
    sb_on  = 1'b0;
    En = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!Out_pVDE && n < 200);
    if (n >= 200) chk("restart_timeout", 64'(n), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    En  = 1'b0;
    tick();
    chk_reset("midline_rst");
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
